// File: rtl/rx_sampler_cdr_pkg.sv
// Shared types for the receiver sampling stage: filter output format and
// CDR phase format, sample/correction enums and small helpers.
package filter_package;
   localparam int unsigned FILTER_WIDTH = 16;
   typedef logic signed [FILTER_WIDTH-1:0] FILTER_OUT_FORMAT;
endpackage

package rx_package;
   import filter_package::*;

   localparam int unsigned PHASE_WIDTH = 14;
   typedef logic signed [PHASE_WIDTH-1:0] PHASE_FORMAT;
   localparam PHASE_FORMAT PHASE_MAX = PHASE_FORMAT'((2 ** (PHASE_WIDTH - 1)) - 1);
   localparam PHASE_FORMAT PHASE_MIN = -PHASE_MAX;

   typedef enum logic {
      SAMPLE_DATA,
      SAMPLE_EDGE
   } sample_type_t;

   typedef enum logic [1:0] {
      CORR_NONE,
      CORR_EARLY,
      CORR_LATE
   } corr_t;

   // Non-negative filter output slices to 1.
   function automatic logic slice_bit(input FILTER_OUT_FORMAT v);
      return ~v[FILTER_WIDTH-1];
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == '1) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/rx_sampler_cdr_bbpd.sv
// Bang-bang phase detector: classifies a data/edge/data triplet as early or
// late and emits a registered one-cycle pulse.
module bbpd (
   input  logic clk_sys,
   input  logic rst,
   input  logic d_prev,
   input  logic e,
   input  logic d_cur,
   input  logic strobe,
   output logic early,
   output logic late
);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         early <= 1'b0;
         late  <= 1'b0;
      end else begin
         early <= 1'b0;
         late  <= 1'b0;
         // With a transition exactly one of e==d_cur / e==d_prev holds.
         if (strobe && (d_prev != d_cur)) begin
            if (e == d_cur) late  <= 1'b1;
            else            early <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rx_sampler_cdr.sv
// Receiver sampler with slicer, data/edge alternation, bang-bang CDR phase
// integrator and lock detector, all in the clk_sys emulation domain.
module rx_sampler_cdr
   import filter_package::*;
   import rx_package::*;
#(
   parameter int unsigned KP          = 4,
   parameter int unsigned PHASE_WIDTH = rx_package::PHASE_WIDTH,
   parameter int unsigned LOCK_COUNT  = 64,
   parameter int unsigned UNLOCK_RUN  = 8
) (
   input  logic                          clk_sys,
   input  logic                          rst,
   input  FILTER_OUT_FORMAT              in,
   input  logic                          time_eq_rx,
   output logic                          data_out,
   output logic                          data_valid,
   output logic signed [PHASE_WIDTH-1:0] phase_code,
   output logic                          phase_valid,
   output logic                          locked
);

   localparam logic signed [PHASE_WIDTH:0] SAT_MAX = (PHASE_WIDTH + 1)'((2 ** (PHASE_WIDTH - 1)) - 1);
   localparam logic signed [PHASE_WIDTH:0] SAT_MIN = -SAT_MAX;
   localparam logic signed [PHASE_WIDTH:0] STEP    = (PHASE_WIDTH + 1)'(KP);

   logic         strobe_d;
   logic         capture;
   logic         bit_now;
   sample_type_t sample_type;
   sample_type_t sample_type_next;
   logic         d_prev;
   logic         e_bit;
   logic         edge_seen;
   logic         pd_strobe;
   logic         early;
   logic         late;

   logic signed [PHASE_WIDTH:0]   code_wide;
   logic signed [PHASE_WIDTH:0]   code_sum;
   logic signed [PHASE_WIDTH-1:0] code_next;
   corr_t                         corr_now;
   corr_t                         last_corr;
   logic [7:0]                    alt_cnt;
   logic [7:0]                    alt_next;
   logic [7:0]                    run_cnt;
   logic [7:0]                    run_next;
   logic                          locked_next;

   // Filter output lags the sample event by one registered lookup.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) strobe_d <= 1'b0;
      else     strobe_d <= time_eq_rx;
   end

   assign capture = strobe_d;
   assign bit_now = slice_bit(in);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) sample_type <= SAMPLE_DATA;
      else     sample_type <= sample_type_next;
   end

   always_comb begin
      sample_type_next = sample_type;
      if (capture)
         sample_type_next = (sample_type == SAMPLE_DATA) ? SAMPLE_EDGE : SAMPLE_DATA;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         data_out   <= 1'b0;
         data_valid <= 1'b0;
         d_prev     <= 1'b0;
         e_bit      <= 1'b0;
         edge_seen  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (capture) begin
            if (sample_type == SAMPLE_DATA) begin
               data_out   <= bit_now;
               data_valid <= 1'b1;
               d_prev     <= bit_now;
            end else begin
               e_bit     <= bit_now;
               edge_seen <= 1'b1;
            end
         end
      end
   end

   // An edge is only ever taken after a data sample, so edge_seen implies
   // a full data/edge history is available.
   assign pd_strobe = capture && (sample_type == SAMPLE_DATA) && edge_seen;

   bbpd u_bbpd (
      .clk_sys (clk_sys),
      .rst     (rst),
      .d_prev  (d_prev),
      .e       (e_bit),
      .d_cur   (bit_now),
      .strobe  (pd_strobe),
      .early   (early),
      .late    (late)
   );

   always_comb begin
      code_wide = (PHASE_WIDTH + 1)'(phase_code);
      code_sum  = code_wide;
      if (early)     code_sum = code_wide + STEP;
      else if (late) code_sum = code_wide - STEP;
      if (code_sum > SAT_MAX)      code_sum = SAT_MAX;
      else if (code_sum < SAT_MIN) code_sum = SAT_MIN;
      code_next = code_sum[PHASE_WIDTH-1:0];
   end

   always_comb begin
      corr_now = CORR_NONE;
      if (early)     corr_now = CORR_EARLY;
      else if (late) corr_now = CORR_LATE;
      alt_next    = alt_cnt;
      run_next    = run_cnt;
      locked_next = locked;
      if (corr_now != CORR_NONE) begin
         if ((last_corr != CORR_NONE) && (last_corr != corr_now)) begin
            alt_next = sat_inc8(alt_cnt);
            run_next = 8'd1;
         end else begin
            alt_next = '0;
            run_next = sat_inc8(run_cnt);
         end
         if (32'(run_next) >= UNLOCK_RUN)      locked_next = 1'b0;
         else if (32'(alt_next) >= LOCK_COUNT) locked_next = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         phase_code  <= '0;
         phase_valid <= 1'b0;
         locked      <= 1'b0;
         alt_cnt     <= '0;
         run_cnt     <= '0;
         last_corr   <= CORR_NONE;
      end else begin
         phase_valid <= early | late;
         if (early | late) begin
            phase_code <= code_next;
            last_corr  <= corr_now;
         end
         alt_cnt <= alt_next;
         run_cnt <= run_next;
         locked  <= locked_next;
      end
   end

endmodule

// File: doc/rx_sampler_cdr.md
# rx_sampler_cdr

Receiver sampling stage directly downstream of the channel filter. On every receiver sample event it captures the filter output, slices it to a bit, and alternates samples between data and edge positions. Data/edge/data triplets drive a bang-bang phase detector whose integrated phase code is returned to the receiver clock generator. Runs entirely in the `clk_sys` emulation domain.

## Interface
- `KP`, 4: phase-code step per detected early/late decision (unsigned).
- `PHASE_WIDTH`, 14: signed width of `phase_code`.
- `LOCK_COUNT`, 64: consecutive sign-alternating corrections required to assert `locked`.
- `UNLOCK_RUN`, 8: consecutive same-sign corrections that drop `locked`.

Ports:
- `clk_sys`  in  1  emulation system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  FILTER_OUT_FORMAT  filter output (signed fixed point).
- `time_eq_rx`  in  1  current emulated time equals a receiver sample event.
- `data_out`  out  1  sliced data bit.
- `data_valid`  out  1  one-cycle strobe qualifying `data_out`.
- `phase_code`  out  PHASE_WIDTH  signed integrated CDR correction (PHASE_FORMAT).
- `phase_valid`  out  1  one-cycle strobe when `phase_code` changed.
- `locked`  out  1  CDR lock indicator.

## Operation
- `in` is valid one `clk_sys` cycle after `time_eq_rx` (filter PWL lookup is registered); block delays `time_eq_rx` by one cycle internally and captures `in` when the delayed strobe is high.
- Slicer: bit = 1 when `in` >= 0, else 0 (sign bit inverted).
- Sample-type toggle: first capture after reset is a data sample; each capture flips the type (data, edge, data, edge, ...).
- Data capture: `data_out` <= bit, `data_valid` pulses; previous data bit retained as `d_prev`.
- Edge capture: bit stored as `e`, no output strobe.
- Phase detector, evaluated on every data capture after at least one prior data and one edge:
  - `d_prev == d_cur`: no transition, no update.
  - `e == d_cur`: late -> `phase_code` -= KP.
  - `e == d_prev`: early -> `phase_code` += KP.
- `phase_code` saturates at ±(2^(PHASE_WIDTH-1) - 1); a saturated step still pulses `phase_valid`.
- Lock detect: 8-bit alternation counter increments when correction sign differs from previous correction, else resets to 0 and same-sign run counter increments. `locked` sets when alternation counter reaches LOCK_COUNT; clears when same-sign run reaches UNLOCK_RUN. Counters saturate.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `phase_code`=0, `phase_valid`=0, `locked`=0; toggle returns to data, `d_prev`/`e` history invalidated, all counters 0.
- Reset mid-operation discards any in-flight capture; first event after release is a data sample.
- `time_eq_rx` high in cycle t: `in` captured at end of t+1; `data_valid` high in t+2 (data sample).
- `phase_code`/`phase_valid` update in t+3 (one registered PD stage); `locked` updates in t+3 with it.
- `time_eq_rx` may assert on back-to-back cycles; pipeline accepts one event per cycle, no stall, no drop.
- No handshake back-pressure; all strobes are single-cycle.

## Structure
- `rx_package`: `PHASE_WIDTH` default, `PHASE_FORMAT` typedef, `PHASE_MAX`/`PHASE_MIN` constants; imports `filter_package` for FILTER_OUT_FORMAT.
- Sub-module `bbpd`: takes `d_prev`, `e`, `d_cur`, strobe; outputs registered early/late pulses. Top level holds slicer, toggle, integrator, lock detect.

## Test plan
- Reset: hold `rst`, drive `in`=+0.5, `time_eq_rx`=1 -> all outputs 0; release, strobe once -> `data_valid` two cycles later, `data_out`=1.
- Slicer boundary: `in`=0 -> 1; `in`=-1 LSB -> 0; `in`=most-negative -> 0.
- Early: data +, edge +, data - (d_prev=1, e=1, d_cur=0) -> `phase_code` 0 -> +4, `phase_valid` one cycle, at t+3 of final strobe.
- Late/no-transition: 1,0,0 -> -4; 1,x,1 -> no change, no `phase_valid`.
- Saturation and lock: 3000 repeated early triplets -> `phase_code` stops at +8191, `locked`=0; then 64 alternating early/late -> `locked`=1; then 8 consecutive late -> `locked`=0.
- Back-to-back strobes every cycle for 1000 events with random signs -> data sequence matches reference slicer model, no missed strobe; `rst` pulse mid-stream -> history cleared, next event is data.
